// File: rtl/ps2_device_tx_if.sv
// Signal bundle between a keystroke source and the PS/2 device transmitter.
// The master side enqueues scan codes and drives inhibit; the slave side is the transmitter.
interface ps2_device_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          key_action;
  logic [7:0]    scan_code;
  logic          host_inhibit;
  logic          ps2_clk;
  logic          ps2_dat;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output key_action, scan_code, host_inhibit,
    input  ps2_clk, ps2_dat, busy, fifo_count, overflow
  );

  modport slave (
    input  key_action, scan_code, host_inhibit,
    output ps2_clk, ps2_dat, busy, fifo_count, overflow
  );
endinterface

// File: rtl/ps2_device_tx.sv
// FIFO-buffered PS/2 device transmitter: serialises queued scan codes as 11-bit frames,
// aborting and resending the head byte whenever the host inhibits before the stop bit.
//
// state  | meaning
// S_IDLE | lines high, waiting for a queued byte and no inhibit
// S_HIGH | ps2_clk high phase of the current bit, data driven
// S_LOW  | ps2_clk low phase of the current bit, host samples
// S_GAP  | both lines high after a frame or an abort
module ps2_device_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 16,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  ps2_device_tx_if.slave bus
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] PHASE_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    STOP_BIT   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   frame_q, frame_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, full, tmr_done, abort;
  logic [7:0]    head;
  logic          parity;

  assign head     = mem_q[rd_ptr_q];
  assign parity   = (^head) ^ ODD_PARITY;
  assign tmr_done = (tmr_q == '0);
  // Inhibit only matters before the stop bit; once bit 10 is on the line the byte counts as sent.
  assign abort    = bus.host_inhibit && (bit_q != STOP_BIT);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !bus.host_inhibit) begin
          state_d = S_HIGH;
          tmr_d   = PHASE_LOAD;
          bit_d   = '0;
          frame_d = {1'b1, parity, head, 1'b0};
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d = S_GAP;
          tmr_d   = GAP_LOAD;
        end else if (tmr_done) begin
          state_d = S_LOW;
          tmr_d   = PHASE_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_GAP;
          tmr_d   = GAP_LOAD;
        end else if (tmr_done) begin
          if (bit_q == STOP_BIT) begin
            state_d = S_GAP;
            tmr_d   = GAP_LOAD;
            pop     = 1'b1;
          end else begin
            state_d = S_HIGH;
            tmr_d   = PHASE_LOAD;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_done) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write to a full queue still lands.
  assign full = (count_q == FULL_COUNT);
  assign push = bus.key_action && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q | (bus.key_action & full & ~pop);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.scan_code;
    end
  end

  assign bus.ps2_clk    = (state_q != S_LOW);
  assign bus.ps2_dat    = ((state_q == S_HIGH) || (state_q == S_LOW)) ? frame_q[bit_q] : 1'b1;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: two instances (odd parity default, even parity fast/small), line
// decoder monitor checked against a byte-level scoreboard queue fed by the stimulus.
module tb_ps2_device_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ka  [2];
  logic [7:0] sc  [2];
  logic       inh [2];
  logic       m_clk [2];
  logic       m_dat [2];
  logic       m_busy[2];
  logic       m_ovf [2];
  int         m_cnt [2];

  int cdiv [2] = '{4, 2};
  int gapc [2] = '{16, 3};
  int depth[2] = '{8, 4};
  bit oddp [2] = '{1'b1, 1'b0};

  ps2_device_tx_if #(.FIFO_DEPTH(8)) bus0 ();
  ps2_device_tx_if #(.FIFO_DEPTH(4)) bus1 ();

  ps2_device_tx #(.CLK_DIV(4), .FIFO_DEPTH(8), .GAP_CYCLES(16), .ODD_PARITY(1'b1)) dut0 (
    .CLOCK_50(clk), .reset(rst), .bus(bus0.slave));
  ps2_device_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .GAP_CYCLES(3), .ODD_PARITY(1'b0)) dut1 (
    .CLOCK_50(clk), .reset(rst), .bus(bus1.slave));

  assign bus0.key_action   = ka[0];
  assign bus0.scan_code    = sc[0];
  assign bus0.host_inhibit = inh[0];
  assign bus1.key_action   = ka[1];
  assign bus1.scan_code    = sc[1];
  assign bus1.host_inhibit = inh[1];
  assign m_clk[0]  = bus0.ps2_clk;
  assign m_dat[0]  = bus0.ps2_dat;
  assign m_busy[0] = bus0.busy;
  assign m_ovf[0]  = bus0.overflow;
  assign m_cnt[0]  = int'(bus0.fifo_count);
  assign m_clk[1]  = bus1.ps2_clk;
  assign m_dat[1]  = bus1.ps2_dat;
  assign m_busy[1] = bus1.busy;
  assign m_ovf[1]  = bus1.overflow;
  assign m_cnt[1]  = int'(bus1.fifo_count);

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q [2][$];
  bit         exp_ovf[2];
  logic [7:0] burst_q[$];

  int          mon_n[2], since_fall[2], hi_run[2], gap_cnt[2], falls[2];
  logic [10:0] bits[2];
  bit          prev[2], armed[2], inh_seen[2], cnt_pending[2];

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, expv, $time);
    end
  endtask

  // Expected wire image, index 0 first on the line: start, data LSB first, parity, stop.
  function automatic logic [10:0] frame_of(logic [7:0] b, bit odd);
    int   ones;
    logic par;
    ones = $countones(b);
    par  = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return {1'b1, par, b, 1'b0};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mon_n[i] = 0; prev[i] = 1'b1; hi_run[i] = 0; armed[i] = 1'b0;
        cnt_pending[i] = 1'b0; since_fall[i] = 0;
      end else begin
        hi_run[i] = m_clk[i] ? hi_run[i] + 1 : 0;
        if (prev[i] && !m_clk[i]) begin
          falls[i]++;
          if (mon_n[i] > 0) chk($sformatf("bit_period%0d", i), since_fall[i], 2 * cdiv[i]);
          since_fall[i] = 1;
          bits[i][mon_n[i]] = m_dat[i];
          mon_n[i]++;
          if (mon_n[i] == 11) begin
            if (exp_q[i].size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_frame%0d actual=0x%0h expected=none", i, bits[i]);
            end else begin
              logic [7:0] b;
              b = exp_q[i].pop_front();
              chk($sformatf("frame%0d", i), int'(bits[i]), int'(frame_of(b, oddp[i])));
            end
            mon_n[i] = 0;
            armed[i] = (exp_q[i].size() > 0);
            inh_seen[i] = 1'b0;
            gap_cnt[i] = 0;
            cnt_pending[i] = 1'b1;
          end
        end else begin
          since_fall[i]++;
        end
        // Lines high longer than one phase mid-frame means the host aborted it; the byte is resent.
        if (mon_n[i] > 0 && hi_run[i] > cdiv[i]) mon_n[i] = 0;
        if (!m_clk[i]) chk($sformatf("busy_in_low%0d", i), int'(m_busy[i]), 1);
        if (cnt_pending[i] && m_clk[i]) begin
          chk($sformatf("fifo_count_after_pop%0d", i), m_cnt[i], exp_q[i].size());
          chk($sformatf("overflow%0d", i), int'(m_ovf[i]), int'(exp_ovf[i]));
          cnt_pending[i] = 1'b0;
        end
        if (armed[i]) begin
          if (inh[i]) inh_seen[i] = 1'b1;
          if (m_clk[i] && m_dat[i]) gap_cnt[i]++;
          else if (m_clk[i] && !m_dat[i]) begin
            if (!inh_seen[i]) chk($sformatf("gap%0d", i), gap_cnt[i], gapc[i] + 1);
            armed[i] = 1'b0;
          end
        end
        prev[i] = m_clk[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(int i, logic [7:0] b);
    if (exp_q[i].size() < depth[i]) exp_q[i].push_back(b);
    else exp_ovf[i] = 1'b1;
  endtask

  task automatic write1(int i, logic [7:0] b);
    sc[i] = b;
    ka[i] = 1'b1;
    @(posedge clk);
    accept(i, b);
    #1;
    ka[i] = 1'b0;
  endtask

  task automatic write_burst(int i);
    foreach (burst_q[k]) begin
      sc[i] = burst_q[k];
      ka[i] = 1'b1;
      @(posedge clk);
      accept(i, burst_q[k]);
      #1;
    end
    ka[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (exp_q[i].size() == 0 && !m_busy[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("drain_in_time%0d", i), int'(ok), 1);
  endtask

  task automatic wait_n(int i, int n, int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (mon_n[i] == n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("reach_bit%0d_inst%0d", n, i), int'(ok), 1);
  endtask

  task automatic random_run(int i, int n);
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 3000 && exp_q[i].size() >= depth[i] - 2; w++) tick();
      write1(i, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 30)) tick();
      if ($urandom_range(0, 7) == 0) begin
        inh[i] = 1'b1;
        repeat ($urandom_range(1, 6)) tick();
        inh[i] = 1'b0;
      end
    end
    wait_idle(i, 8000);
  endtask

  initial begin
    int f0;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      ka[i] = 1'b0; sc[i] = 8'h00; inh[i] = 1'b0; exp_ovf[i] = 1'b0; falls[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_clk", int'(m_clk[0]), 1);
    chk("rst_dat", int'(m_dat[0]), 1);
    chk("rst_busy", int'(m_busy[0]), 0);
    chk("rst_count", m_cnt[0], 0);
    chk("rst_overflow", int'(m_ovf[0]), 0);
    tick();

    // Single byte and first-bit latency.
    write1(0, 8'h1C);
    chk("lat_dat_idle", int'(m_dat[0]), 1);
    chk("lat_busy_idle", int'(m_busy[0]), 0);
    chk("lat_count", m_cnt[0], 1);
    tick();
    chk("lat_dat_start", int'(m_dat[0]), 0);
    chk("lat_busy_start", int'(m_busy[0]), 1);
    chk("lat_clk_start", int'(m_clk[0]), 1);
    wait_idle(0, 400);

    // Make / break sequence on consecutive cycles.
    burst_q.delete();
    burst_q.push_back(8'h1C); burst_q.push_back(8'hF0); burst_q.push_back(8'h1C);
    write_burst(0);
    chk("burst_count", m_cnt[0], 3);
    wait_idle(0, 1000);

    // Inhibit during bit 4: abort, keep the byte, resend it.
    write1(0, 8'h1A);
    wait_n(0, 5, 300);
    inh[0] = 1'b1;
    tick();
    chk("abort_clk", int'(m_clk[0]), 1);
    chk("abort_dat", int'(m_dat[0]), 1);
    chk("abort_no_pop", m_cnt[0], 1);
    repeat (4) tick();
    inh[0] = 1'b0;
    wait_idle(0, 600);

    // Inhibit during the stop bit is ignored.
    write1(0, 8'h3C);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (mon_n[0] == 10 && m_clk[0]) begin ok = 1'b1; break; end
      tick();
    end
    chk("reach_stop_high", int'(ok), 1);
    inh[0] = 1'b1;
    repeat (3) tick();
    inh[0] = 1'b0;
    wait_idle(0, 400);

    // Fill past capacity while inhibited.
    inh[0] = 1'b1;
    tick();
    f0 = falls[0];
    burst_q.delete();
    for (int k = 0; k < 9; k++) burst_q.push_back(8'($urandom_range(0, 255)));
    write_burst(0);
    repeat (20) tick();
    chk("full_count", m_cnt[0], 8);
    chk("full_overflow", int'(m_ovf[0]), 1);
    chk("full_busy", int'(m_busy[0]), 0);
    chk("inhibit_no_clock", falls[0], f0);
    inh[0] = 1'b0;
    wait_idle(0, 3000);
    chk("overflow_sticky", int'(m_ovf[0]), 1);

    // Reset during bit 6.
    write1(0, 8'h5A);
    wait_n(0, 7, 300);
    rst = 1'b1;
    #1;
    chk("midrst_clk", int'(m_clk[0]), 1);
    chk("midrst_dat", int'(m_dat[0]), 1);
    chk("midrst_busy", int'(m_busy[0]), 0);
    chk("midrst_count", m_cnt[0], 0);
    chk("midrst_overflow", int'(m_ovf[0]), 0);
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      exp_ovf[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    write1(0, 8'h2B);
    wait_idle(0, 400);

    random_run(0, 40);

    // Even-parity instance with short timing.
    write1(1, 8'h1A);
    wait_idle(1, 300);
    write1(1, 8'h1B);
    wait_idle(1, 300);
    burst_q.delete();
    for (int k = 0; k < 3; k++) burst_q.push_back(8'($urandom_range(0, 255)));
    write_burst(1);
    wait_idle(1, 600);
    random_run(1, 25);

    chk("end_count0", m_cnt[0], 0);
    chk("end_count1", m_cnt[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
